// File: rtl/vme_bus_requester_if.sv
// Signal bundle between a local bus-master card and the VME arbitration pins.
// master: the requester block; slave: the local master/bus side that drives it.
interface vme_bus_requester_if;
  logic req;
  logic cycle_active;
  logic grant;
  logic br_n;
  logic bg_in_n;
  logic bg_out_n;
  logic bbsy_n_in;
  logic bbsy_n_out;
  logic bclr_n;
  logic as_n_in;

  modport master (
    input  req, cycle_active, bg_in_n, bbsy_n_in, bclr_n, as_n_in,
    output grant, br_n, bg_out_n, bbsy_n_out
  );

  modport slave (
    output req, cycle_active, bg_in_n, bbsy_n_in, bclr_n, as_n_in,
    input  grant, br_n, bg_out_n, bbsy_n_out
  );
endinterface

// File: rtl/vme_bus_requester.sv
// VME bus requester: requests on a fixed BR level, owns the bus via BBSY, releases on idle or
// BCLR, and passes BG down the daisy chain when not requesting.
module vme_bus_requester #(
  parameter bit          RELEASE_ON_CLEAR = 1'b1,
  parameter int unsigned BBSY_MIN         = 3
) (
  input logic                 clock,
  input logic                 reset,
  vme_bus_requester_if.master bus
);

  localparam int unsigned CntW = (BBSY_MIN > 1) ? $clog2(BBSY_MIN) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StWaitBus,
    StOwner,
    StRelease
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            grant_q, grant_d;
  logic            br_n_q, br_n_d;
  logic            bg_out_n_q, bg_out_n_d;
  logic            bbsy_n_out_q, bbsy_n_out_d;

  // Two-stage synchronisers, idle (high) on reset: {as, bclr, bbsy, bg}.
  logic [3:0] sync1_q, sync2_q;
  logic       bg_in_s, bbsy_s, bclr_s, as_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {bus.as_n_in, bus.bclr_n, bus.bbsy_n_in, bus.bg_in_n};
      sync2_q <= sync1_q;
    end
  end

  assign bg_in_s = sync2_q[0];
  assign bbsy_s  = sync2_q[1];
  assign bclr_s  = sync2_q[2];
  assign as_s    = sync2_q[3];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = 1'b0;
    br_n_d       = 1'b1;
    bg_out_n_d   = 1'b1;
    bbsy_n_out_d = 1'b1;

    case (state_q)
      StIdle: begin
        bg_out_n_d = bg_in_s;
        // A grant already passing through wins over a new request.
        if (bus.req && bg_in_s) begin
          state_d    = StRequest;
          br_n_d     = 1'b0;
          bg_out_n_d = 1'b1;
        end
      end

      StRequest: begin
        br_n_d = 1'b0;
        if (!bg_in_s) begin
          state_d = StWaitBus;
        end
      end

      StWaitBus: begin
        br_n_d = 1'b0;
        if (bbsy_s && as_s) begin
          state_d      = StOwner;
          grant_d      = 1'b1;
          bbsy_n_out_d = 1'b0;
          br_n_d       = 1'b1;
          cnt_d        = CntW'(BBSY_MIN - 1);
        end
      end

      StOwner: begin
        grant_d      = 1'b1;
        bbsy_n_out_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end
        // Never abandon a transfer in progress, even under BCLR.
        if ((cnt_q == '0) && !bus.cycle_active &&
            (!bus.req || (RELEASE_ON_CLEAR && !bclr_s))) begin
          state_d      = StRelease;
          grant_d      = 1'b0;
          bbsy_n_out_d = 1'b1;
        end
      end

      StRelease: begin
        // Wait for the arbiter to drop our grant so it is not mistaken for a fresh one.
        if (bg_in_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      br_n_q       <= 1'b1;
      bg_out_n_q   <= 1'b1;
      bbsy_n_out_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      br_n_q       <= br_n_d;
      bg_out_n_q   <= bg_out_n_d;
      bbsy_n_out_q <= bbsy_n_out_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.br_n       = br_n_q;
  assign bus.bg_out_n   = bg_out_n_q;
  assign bus.bbsy_n_out = bbsy_n_out_q;

endmodule
